inmux_ctrl_2_5: RTL and testbench

- Return-path arbiter for the 2_5 kernel group. Kernels 8, 9, 13, 14 and 15 each raise a request toward a single shared downstream consumer.
- The block picks one kernel round-robin, locks the grant for up to BURST transfers, and forwards the handshake between the winner and the consumer.
- It drives `sel`, which steers the external data mux.
- It is the gather-side counterpart of the oumux scatter control.

---
 rtl/inmux_ctrl_2_5_if.sv | 25 ++
 rtl/inmux_ctrl_2_5.sv | 136 +++++++++++++
 tb/tb_inmux_ctrl_2_5.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/inmux_ctrl_2_5_if.sv
// Handshake bundle between the 2_5 return-path arbiter and its kernels/consumer.
// master = arbiter side, slave = kernels + downstream consumer side.
interface inmux_ctrl_2_5_if;
  logic       t_k8_req,  t_k8_ack;
  logic       t_k9_req,  t_k9_ack;
  logic       t_k13_req, t_k13_ack;
  logic       t_k14_req, t_k14_ack;
  logic       t_k15_req, t_k15_ack;
  logic       i_inmux_req, i_inmux_ack;
  logic [3:0] sel;
  logic       sel_valid;
  logic       err_wdog;

  modport master (
    input  t_k8_req, t_k9_req, t_k13_req, t_k14_req, t_k15_req, i_inmux_ack,
    output t_k8_ack, t_k9_ack, t_k13_ack, t_k14_ack, t_k15_ack, i_inmux_req,
    output sel, sel_valid, err_wdog
  );

  modport slave (
    output t_k8_req, t_k9_req, t_k13_req, t_k14_req, t_k15_req, i_inmux_ack,
    input  t_k8_ack, t_k9_ack, t_k13_ack, t_k14_ack, t_k15_ack, i_inmux_req,
    input  sel, sel_valid, err_wdog
  );
endinterface

// File: rtl/inmux_ctrl_2_5.sv
// Round-robin gather arbiter for kernels 8/9/13/14/15 onto one consumer, with burst lock.
// Optional stall watchdog enabled by defining INMUX_WDOG_EN.

// Per-kernel handshake gating: only the granted lane sees the consumer ack.
module inmux_ctrl_2_5_lane (
  input  logic req,
  input  logic hit,
  input  logic c_ack,
  output logic fwd,
  output logic ack
);
  assign fwd = hit & req;
  assign ack = fwd & c_ack;
endmodule

module inmux_ctrl_2_5 #(
  parameter int BURST       = 4,
  parameter int WDOG_CYCLES = 64
) (
  input logic               clk,
  input logic               reset,
  inmux_ctrl_2_5_if.master  bus
);
  localparam int NUM_LANES = 5;
  localparam logic [NUM_LANES-1:0][3:0] KID = {4'd15, 4'd14, 4'd13, 4'd9, 4'd8};
  localparam logic [3:0] BURST_LAST = 4'(BURST - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t               state;
  logic [2:0]           sel_idx, rr_last, pick_idx;
  logic [3:0]           burst_cnt, sel_q;
  logic                 sel_valid_q, pick_vld;
  logic                 active, win_req, xfer, burst_done, wdog_trip;
  logic [NUM_LANES-1:0] req_v, hit_v, fwd_v, ack_v;

  function automatic logic [2:0] nxt(input logic [2:0] base, input int off);
    return 3'((int'(base) + off) % NUM_LANES);
  endfunction

  assign req_v = {bus.t_k15_req, bus.t_k14_req, bus.t_k13_req, bus.t_k9_req, bus.t_k8_req};

  // Gated by reset so an aborted grant never acks in the reset cycle.
  assign active     = (state == GRANT) && !reset;
  assign win_req    = req_v[sel_idx];
  assign xfer       = (state == GRANT) && win_req && bus.i_inmux_ack;
  assign burst_done = xfer && (burst_cnt == BURST_LAST);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    assign hit_v[i] = active && (sel_idx == 3'(i));
    inmux_ctrl_2_5_lane u_lane (
      .req   (req_v[i]),
      .hit   (hit_v[i]),
      .c_ack (bus.i_inmux_ack),
      .fwd   (fwd_v[i]),
      .ack   (ack_v[i])
    );
  end

  assign bus.t_k8_ack    = ack_v[0];
  assign bus.t_k9_ack    = ack_v[1];
  assign bus.t_k13_ack   = ack_v[2];
  assign bus.t_k14_ack   = ack_v[3];
  assign bus.t_k15_ack   = ack_v[4];
  assign bus.i_inmux_req = |fwd_v;
  assign bus.sel         = sel_q;
  assign bus.sel_valid   = sel_valid_q;

  // Walk farthest-to-nearest after rr_last so the nearest requester is the final pick.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int i = NUM_LANES; i >= 1; i--) begin
      if (req_v[nxt(rr_last, i)]) begin
        pick_vld = 1'b1;
        pick_idx = nxt(rr_last, i);
      end
    end
  end

`ifdef INMUX_WDOG_EN
  logic [7:0] wdog_cnt;
  logic       err_q, stall;

  assign stall     = (state == GRANT) && win_req && !bus.i_inmux_ack;
  assign wdog_trip = stall && (wdog_cnt == 8'(WDOG_CYCLES - 1));
  assign bus.err_wdog = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wdog_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != GRANT || xfer) wdog_cnt <= '0;
      else if (stall)             wdog_cnt <= wdog_cnt + 8'd1;
      if (wdog_trip) err_q <= 1'b1;
    end
  end
`else
  assign wdog_trip    = 1'b0;
  assign bus.err_wdog = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      sel_q       <= '0;
      sel_idx     <= '0;
      sel_valid_q <= 1'b0;
      rr_last     <= 3'(NUM_LANES - 1);
      burst_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            sel_idx     <= pick_idx;
            sel_q       <= KID[pick_idx];
            sel_valid_q <= 1'b1;
            burst_cnt   <= '0;
            state       <= GRANT;
          end
        end
        GRANT: begin
          if (xfer) burst_cnt <= burst_cnt + 4'd1;
          // sel is held on exit so the external mux never glitches between grants.
          if (burst_done || !win_req || wdog_trip) begin
            sel_valid_q <= 1'b0;
            rr_last     <= sel_idx;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_inmux_ctrl_2_5.sv
// Scoreboard bench for inmux_ctrl_2_5: one instance with BURST=1, one with BURST=4.
// Expected transfers (kernel, cycle gap to previous transfer) are queued; a negedge monitor checks them.
module tb_inmux_ctrl_2_5;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  inmux_ctrl_2_5_if if1();
  inmux_ctrl_2_5_if if4();

  inmux_ctrl_2_5 #(.BURST(1), .WDOG_CYCLES(8))  u_dut1 (.clk(clk), .reset(reset), .bus(if1));
  inmux_ctrl_2_5 #(.BURST(4), .WDOG_CYCLES(64)) u_dut4 (.clk(clk), .reset(reset), .bus(if4));

  typedef struct {int k; int gap;} exp_t;
  exp_t q1[$];
  exp_t q4[$];
  int tests = 0, fails = 0;
  int cyc = 0, last1 = 0, last4 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int kid(input logic [4:0] a);
    case (a)
      5'b00001: return 8;
      5'b00010: return 9;
      5'b00100: return 13;
      5'b01000: return 14;
      5'b10000: return 15;
      default:  return -1;
    endcase
  endfunction

  function automatic logic [4:0] acks(input int which);
    if (which == 1) return {if1.t_k15_ack, if1.t_k14_ack, if1.t_k13_ack, if1.t_k9_ack, if1.t_k8_ack};
    return {if4.t_k15_ack, if4.t_k14_ack, if4.t_k13_ack, if4.t_k9_ack, if4.t_k8_ack};
  endfunction

  task automatic set_reqs(input int which, input logic [4:0] v);
    if (which == 1) begin
      if1.t_k8_req = v[0]; if1.t_k9_req = v[1]; if1.t_k13_req = v[2];
      if1.t_k14_req = v[3]; if1.t_k15_req = v[4];
    end else begin
      if4.t_k8_req = v[0]; if4.t_k9_req = v[1]; if4.t_k13_req = v[2];
      if4.t_k14_req = v[3]; if4.t_k15_req = v[4];
    end
  endtask

  task automatic exp_push(input int which, input int k, input int gap);
    exp_t e;
    e.k = k; e.gap = gap;
    if (which == 1) q1.push_back(e); else q4.push_back(e);
  endtask

  task automatic mon_step(input int which, input logic [4:0] a, input logic [3:0] s);
    exp_t e;
    int   k, last;
    if ($isunknown(a) || a == 5'b0) return;
    k    = kid(a);
    last = (which == 1) ? last1 : last4;
    if ((which == 1 && q1.size() == 0) || (which == 4 && q4.size() == 0)) begin
      tests++; fails++;
      $display("FAIL dut%0d_unexpected_ack: got kernel %0d expected none", which, k);
    end else begin
      e = (which == 1) ? q1.pop_front() : q4.pop_front();
      chk($sformatf("dut%0d_ack_kernel", which), k, e.k);
      chk($sformatf("dut%0d_sel_vs_ack", which), 32'(s), k);
      if (e.gap != 0) chk($sformatf("dut%0d_ack_gap", which), cyc - last, e.gap);
    end
    if (which == 1) last1 = cyc; else last4 = cyc;
  endtask

  always @(negedge clk) begin
    cyc++;
    mon_step(1, acks(1), if1.sel);
    mon_step(4, acks(4), if4.sel);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    reset = 1'b1;
    set_reqs(1, 5'b0); set_reqs(4, 5'b0);
    if1.i_inmux_ack = 1'b0; if4.i_inmux_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  initial begin
    // Reset held with every kernel requesting
    reset = 1'b1;
    set_reqs(1, 5'h1F); set_reqs(4, 5'h1F);
    if1.i_inmux_ack = 1'b1; if4.i_inmux_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_acks", 32'(acks(4)), 0);
      chk("rst_inmux_req", 32'(if4.i_inmux_req), 0);
      chk("rst_sel", 32'(if4.sel), 0);
      chk("rst_sel_valid", 32'(if4.sel_valid), 0);
    end
    if1.i_inmux_ack = 1'b0; if4.i_inmux_ack = 1'b0;
    reset = 1'b0;
    tick();
    chk("first_grant_sel", 32'(if4.sel), 8);
    chk("first_grant_valid", 32'(if4.sel_valid), 1);
    chk("first_grant_sel_b1", 32'(if1.sel), 8);

    // Reset in the middle of a grant: no ack in the reset cycle
    if4.i_inmux_ack = 1'b1;
    reset = 1'b1;
    #1;
    chk("midrst_acks", 32'(acks(4)), 0);
    chk("midrst_inmux_req", 32'(if4.i_inmux_req), 0);
    reset_all();

    // Round robin, BURST=1, all requesting
    exp_push(1, 8, 0);
    exp_push(1, 9, 2); exp_push(1, 13, 2); exp_push(1, 14, 2);
    exp_push(1, 15, 2); exp_push(1, 8, 2);
    set_reqs(1, 5'h1F);
    if1.i_inmux_ack = 1'b1;
    repeat (12) tick();
    set_reqs(1, 5'b0);
    if1.i_inmux_ack = 1'b0;
    tick(); tick();

    // Burst limit, BURST=4, k13 and k15
    reset_all();
    for (int i = 0; i < 4; i++) exp_push(4, 13, (i == 0) ? 0 : 1);
    for (int i = 0; i < 4; i++) exp_push(4, 15, (i == 0) ? 2 : 1);
    set_reqs(4, 5'b10100);
    if4.i_inmux_ack = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("burst_sel_13", 32'(if4.sel), 13);
    end
    tick();
    chk("burst_idle_gap", 32'(if4.sel_valid), 0);
    tick();
    chk("burst_sel_15", 32'(if4.sel), 15);
    repeat (4) tick();
    set_reqs(4, 5'b0);
    if4.i_inmux_ack = 1'b0;
    tick(); tick();

    // Withdraw: k9 drops after 2 transfers, k13 is next
    reset_all();
    exp_push(4, 9, 0); exp_push(4, 9, 1); exp_push(4, 13, 3);
    set_reqs(4, 5'b00110);
    if4.i_inmux_ack = 1'b1;
    tick();
    chk("wd_sel_9", 32'(if4.sel), 9);
    tick(); tick();
    set_reqs(4, 5'b00100);
    tick();
    chk("wd_idle", 32'(if4.sel_valid), 0);
    tick();
    chk("wd_sel_13", 32'(if4.sel), 13);
    tick();
    set_reqs(4, 5'b0);
    if4.i_inmux_ack = 1'b0;
    tick(); tick();

    // Back-pressure on k14: ten stalled cycles, one transfer on cycle 11
    reset_all();
    exp_push(4, 14, 0);
    set_reqs(4, 5'b01000);
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk($sformatf("bp_no_ack_c%0d", i), 32'(if4.t_k14_ack), 0);
    end
    chk("bp_sel_14", 32'(if4.sel), 14);
    tick();
    if4.i_inmux_ack = 1'b1;
    #1;
    chk("bp_ack_c11", 32'(if4.t_k14_ack), 1);
    tick();
    set_reqs(4, 5'b0);
    if4.i_inmux_ack = 1'b0;
    chk("bp_no_wdog", 32'(if4.err_wdog), 0);
    tick(); tick();

`ifdef INMUX_WDOG_EN
    // Watchdog, WDOG_CYCLES=8 on the BURST=1 instance
    reset_all();
    set_reqs(1, 5'b00011);
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk($sformatf("wdog_hold_c%0d", i), 32'(if1.sel_valid), 1);
      chk($sformatf("wdog_err_low_c%0d", i), 32'(if1.err_wdog), 0);
    end
    tick();
    chk("wdog_err_set", 32'(if1.err_wdog), 1);
    chk("wdog_exit", 32'(if1.sel_valid), 0);
    tick();
    chk("wdog_next_sel_9", 32'(if1.sel), 9);
    exp_push(1, 9, 0);
    if1.i_inmux_ack = 1'b1;
    tick();
    set_reqs(1, 5'b0);
    if1.i_inmux_ack = 1'b0;
    tick();
    chk("wdog_err_sticky", 32'(if1.err_wdog), 1);
`else
    chk("wdog_tied_low", 32'(if1.err_wdog), 0);
`endif

    tick(); tick();
    chk("q1_drained", q1.size(), 0);
    chk("q4_drained", q4.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
